cpu_fetch: RTL

Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter (PC) and the base address register (BAR).
- Runs a request/acknowledge fetch from instruction memory and holds the fetched word in an instruction register driving the decoder input.
- Consumes the decoder's control outputs (soft reset, PC load, jump mode, base-register offset/load/data) to compute the next PC.
- Presents each instruction with a one-cycle-or-longer commit strobe.

---
 rtl/cpu_fetch.sv | 108 ++++++++++
 1 files changed

// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch : instruction fetch stage in front of the decoder.
//
// Owns the program counter (PC) and base address register (BAR), runs a
// request/acknowledge fetch from instruction memory and holds the fetched word
// in INSTR for the decoder. The decoder's control outputs are consumed on the
// commit edge (leaving EXEC with STALL low) to compute the next PC.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   IMEM_REQ/ADDR     fetch request and address (ADDR is the PC)
//   IMEM_ACK/DATA     memory acknowledge with same-cycle data
//   INSTR/INSTR_VALID instruction register and commit strobe
//   STALL             downstream hold, freezes the commit
//   SOFT_RST, PC_LD, JMP_MODE, BASE_REG_OFFSET, BASE_REG_LD, BASE_REG_DATA
//                     decoder controls, sampled only on the commit edge
//   PC, BAR           current program counter / base address register
// ---------------------------------------------------------------------------
module cpu_fetch #(
   parameter int WIDTH  = 13,
   parameter int IWIDTH = 5
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   output logic                      IMEM_REQ,
   output logic [WIDTH-IWIDTH-1:0]   IMEM_ADDR,
   input  logic                      IMEM_ACK,
   input  logic [WIDTH-1:0]          IMEM_DATA,
   output logic [WIDTH-1:0]          INSTR,
   output logic                      INSTR_VALID,
   input  logic                      STALL,
   input  logic                      SOFT_RST,
   input  logic                      PC_LD,
   input  logic                      JMP_MODE,
   input  logic [WIDTH-IWIDTH-1:0]   BASE_REG_OFFSET,
   input  logic                      BASE_REG_LD,
   input  logic [WIDTH-IWIDTH-1:0]   BASE_REG_DATA,
   output logic [WIDTH-IWIDTH-1:0]   PC,
   output logic [WIDTH-IWIDTH-1:0]   BAR
);

   localparam int AW = WIDTH - IWIDTH;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [AW-1:0]   bar_q, bar_d;
   logic [WIDTH-1:0] instr_q, instr_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pc_q    <= '0;
         bar_q   <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         bar_q   <= bar_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      bar_d   = bar_q;
      instr_d = instr_q;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (IMEM_ACK) begin
               instr_d = IMEM_DATA;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!STALL) begin
               state_d = FETCH;
               if (SOFT_RST) begin
                  pc_d  = '0;
                  bar_d = '0;
               end else begin
                  // Relative jump reads bar_q, so a coincident BAR load
                  // only takes effect for later instructions.
                  if (PC_LD)
                     pc_d = JMP_MODE ? (bar_q + BASE_REG_OFFSET) : BASE_REG_OFFSET;
                  else
                     pc_d = pc_q + AW'(1);
                  if (BASE_REG_LD)
                     bar_d = BASE_REG_DATA;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode state only, so no input reaches an output combinationally.
   assign IMEM_REQ    = (state_q == FETCH);
   assign INSTR_VALID = (state_q == EXEC);
   assign IMEM_ADDR   = pc_q;
   assign INSTR       = instr_q;
   assign PC          = pc_q;
   assign BAR         = bar_q;

endmodule
